// File: rtl/pep_seq_ks_batch_gen_pkg.sv
// Shared types and pointer helpers for the PE-PBS sequencer keyswitch batch former.
// Pointers carry a wrap bit c so that full and empty pools can be told apart.
package pep_seq_ks_batch_gen_pkg;

  localparam int LWE_K_P1      = 3;
  localparam int BATCH_PBS_NB  = 4;
  localparam int TOTAL_PBS_NB  = 6;
  localparam int BATCH_NB      = 2;
  localparam int TIMEOUT_CNT_W = 16;

  localparam int PID_W      = $clog2(TOTAL_PBS_NB);
  localparam int PID_WW     = $clog2(TOTAL_PBS_NB + 1);
  localparam int KS_LOOP_W  = (LWE_K_P1 > 1) ? $clog2(LWE_K_P1) : 1;
  localparam int BATCH_NB_W = $clog2(BATCH_NB + 1);

  typedef struct packed {
    logic             c;
    logic [PID_W-1:0] pt;
  } pointer_t;

  typedef struct packed {
    logic                 ks_loop_c;
    logic [KS_LOOP_W-1:0] ks_loop;
    pointer_t             wp;
    pointer_t             rp;
  } ks_cmd_t;

  localparam int KS_CMD_W = $bits(ks_cmd_t);

  typedef struct packed {
    logic batch_inc;
    logic timeout_inc;
    logic flush_inc;
  } pep_ks_batch_gen_counter_inc_t;

  typedef struct packed {
    logic ldb_ovf;
    logic done_udf;
  } pep_ks_batch_gen_error_t;

  // Number of elements between rp and wp; a differing wrap bit means wp lapped once.
  function automatic logic [PID_WW-1:0] pt_elt_nb(input pointer_t wp, input pointer_t rp);
    int d;
    if (wp.c == rp.c) d = int'(wp.pt) - int'(rp.pt);
    else              d = int'(wp.pt) + TOTAL_PBS_NB - int'(rp.pt);
    return d[PID_WW-1:0];
  endfunction

  function automatic pointer_t pt_inc(input pointer_t p, input logic [PID_WW-1:0] n);
    pointer_t r;
    int       s;
    r = p;
    s = int'(p.pt) + int'(n);
    if (s >= TOTAL_PBS_NB) begin
      s   = s - TOTAL_PBS_NB;
      r.c = ~p.c;
    end
    r.pt = s[PID_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/pep_seq_batch_timeout.sv
// Partial-batch timeout: counts idle cycles with a partial batch pending.
// The count holds once expired so a blocked issue still sees the expiry later.
module pep_seq_batch_timeout
  import pep_seq_ks_batch_gen_pkg::*;
(
  input  logic                     clk,
  input  logic                     s_rst_n,
  input  logic                     run,
  input  logic                     clr,
  input  logic [TIMEOUT_CNT_W-1:0] timeout_val,
  output logic                     expired
);

  logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    expired = (timeout_val != '0) && (cnt_q >= timeout_val - TIMEOUT_CNT_W'(1));
    cnt_d   = cnt_q;
    if (clr)                cnt_d = '0;
    else if (run && !expired) cnt_d = cnt_q + TIMEOUT_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pep_seq_ks_batch_gen.sv
// Keyswitch batch former: tracks the BLWE pool, groups pending PBS into batches
// and issues one ks_cmd beat per ks_loop; pool slots free on ks_done.
module pep_seq_ks_batch_gen
  import pep_seq_ks_batch_gen_pkg::*;
#(
  parameter int KS_LOOP_NB = LWE_K_P1
)
(
  input  logic                     clk,
  input  logic                     s_rst_n,
  input  logic                     ldb_inc,
  input  logic                     flush,
  input  logic [TIMEOUT_CNT_W-1:0] timeout_val,
  output logic [KS_CMD_W-1:0]      ks_cmd,
  output logic                     ks_cmd_vld,
  input  logic                     ks_cmd_rdy,
  input  logic                     ks_done,
  input  logic [PID_W:0]           ks_done_wp,
  output logic [PID_WW-1:0]        pool_free_nb,
  output logic [1:0]               seq_error,
  output logic [2:0]               cnt_inc
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                        state_q, state_d;
  pointer_t                      in_wp_q, in_wp_d;
  pointer_t                      cmd_rp_q, cmd_rp_d;
  pointer_t                      free_rp_q, free_rp_d;
  pointer_t                      batch_rp_q, batch_rp_d;
  pointer_t                      batch_wp_q, batch_wp_d;
  logic [BATCH_NB_W-1:0]         inflight_q, inflight_d;
  logic [KS_LOOP_W-1:0]          beat_q, beat_d;
  logic                          flush_req_q, flush_req_d;
  logic                          ks_loop_c_q, ks_loop_c_d;
  logic                          vld_q, vld_d;
  pep_ks_batch_gen_counter_inc_t cnt_inc_q, cnt_inc_d;
  pep_ks_batch_gen_error_t       err_q, err_d;

  logic [PID_WW-1:0] pend, occ, n_take;
  logic              full, expired, trigger, last_acc, done_ok, tmo_run, tmo_clr;
  ks_cmd_t           cmd;

  always_comb begin
    pend     = pt_elt_nb(in_wp_q, cmd_rp_q);
    occ      = pt_elt_nb(in_wp_q, free_rp_q);
    full     = pend >= PID_WW'(BATCH_PBS_NB);
    n_take   = full ? PID_WW'(BATCH_PBS_NB) : pend;
    trigger  = (state_q == IDLE) && (inflight_q < BATCH_NB_W'(BATCH_NB)) && (pend != '0)
               && (full || expired || flush_req_q);
    last_acc = (state_q == ISSUE) && vld_q && ks_cmd_rdy
               && (beat_q == KS_LOOP_W'(KS_LOOP_NB - 1));
    done_ok  = ks_done && (inflight_q != '0);
    tmo_run  = (state_q == IDLE) && (pend != '0) && !full;
    tmo_clr  = trigger || (pend == '0);
  end

  pep_seq_batch_timeout u_timeout (
    .clk         (clk),
    .s_rst_n     (s_rst_n),
    .run         (tmo_run),
    .clr         (tmo_clr),
    .timeout_val (timeout_val),
    .expired     (expired)
  );

  always_comb begin
    state_d     = state_q;
    in_wp_d     = in_wp_q;
    cmd_rp_d    = cmd_rp_q;
    free_rp_d   = free_rp_q;
    batch_rp_d  = batch_rp_q;
    batch_wp_d  = batch_wp_q;
    inflight_d  = inflight_q;
    beat_d      = beat_q;
    ks_loop_c_d = ks_loop_c_q;
    vld_d       = vld_q;
    err_d       = err_q;
    cnt_inc_d   = '0;

    // Occupancy is judged on registered pointers, so a same-cycle ks_done does not make room.
    if (ldb_inc) begin
      if (occ == PID_WW'(TOTAL_PBS_NB)) err_d.ldb_ovf = 1'b1;
      else                              in_wp_d = pt_inc(in_wp_q, PID_WW'(1));
    end

    if (flush)                      flush_req_d = 1'b1;
    else if (trigger || pend == '0) flush_req_d = 1'b0;
    else                            flush_req_d = flush_req_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d               = ISSUE;
          vld_d                 = 1'b1;
          beat_d                = '0;
          batch_rp_d            = cmd_rp_q;
          batch_wp_d            = pt_inc(cmd_rp_q, n_take);
          cnt_inc_d.batch_inc   = full;
          cnt_inc_d.flush_inc   = !full && flush_req_q;
          cnt_inc_d.timeout_inc = !full && !flush_req_q;
        end
      end
      ISSUE: begin
        if (vld_q && ks_cmd_rdy) begin
          if (last_acc) begin
            state_d     = IDLE;
            vld_d       = 1'b0;
            cmd_rp_d    = batch_wp_q;
            ks_loop_c_d = ~ks_loop_c_q;
          end else begin
            beat_d = beat_q + KS_LOOP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (ks_done) begin
      if (inflight_q == '0) err_d.done_udf = 1'b1;
      else                  free_rp_d      = pointer_t'(ks_done_wp);
    end

    case ({last_acc, done_ok})
      2'b10:   inflight_d = inflight_q + BATCH_NB_W'(1);
      2'b01:   inflight_d = inflight_q - BATCH_NB_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state_q     <= IDLE;
      in_wp_q     <= '0;
      cmd_rp_q    <= '0;
      free_rp_q   <= '0;
      batch_rp_q  <= '0;
      batch_wp_q  <= '0;
      inflight_q  <= '0;
      beat_q      <= '0;
      flush_req_q <= 1'b0;
      ks_loop_c_q <= 1'b0;
      vld_q       <= 1'b0;
      cnt_inc_q   <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_wp_q     <= in_wp_d;
      cmd_rp_q    <= cmd_rp_d;
      free_rp_q   <= free_rp_d;
      batch_rp_q  <= batch_rp_d;
      batch_wp_q  <= batch_wp_d;
      inflight_q  <= inflight_d;
      beat_q      <= beat_d;
      flush_req_q <= flush_req_d;
      ks_loop_c_q <= ks_loop_c_d;
      vld_q       <= vld_d;
      cnt_inc_q   <= cnt_inc_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    cmd.ks_loop_c = ks_loop_c_q;
    cmd.ks_loop   = beat_q;
    cmd.wp        = batch_wp_q;
    cmd.rp        = batch_rp_q;
  end

  assign ks_cmd       = cmd;
  assign ks_cmd_vld   = vld_q;
  assign pool_free_nb = PID_WW'(TOTAL_PBS_NB) - occ;
  assign seq_error    = err_q;
  assign cnt_inc      = cnt_inc_q;

endmodule
